// File: rtl/noc_port_arbiter_pkg.sv
// Shared NoC definitions: port index order and the link packet width.
package pa_noc;

    localparam int APB_PACKET_WIDTH = 32;
    localparam int NUM_PORTS        = 5;

    typedef enum logic [2:0] {
        LOCAL = 3'd0,
        NORTH = 3'd1,
        SOUTH = 3'd2,
        EAST  = 3'd3,
        WEST  = 3'd4
    } port_e;

endpackage

// File: rtl/noc_port_arbiter_rr_pick.sv
// Round-robin winner search: first set request strictly after ptr, with wrap,
// found by masking a doubled request vector and taking the lowest set bit.
module rr_pick
    import pa_noc::*;
#(
    parameter int N = NUM_PORTS,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          found,
    output logic [IW-1:0] idx
);

    logic [2*N-1:0] req2;
    logic [2*N-1:0] window;
    logic [2*N-1:0] masked;

    // NOTE: every variable written here gets a default first, so no latch is inferred.
    always_comb begin
        req2   = {req, req};
        window = '0;
        for (int i = 0; i < 2*N; i++) begin
            window[i] = (i > int'(ptr)) && (i <= int'(ptr) + N);
        end
        masked = req2 & window;

        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < 2*N; i++) begin
            if (!found && masked[i]) begin
                found = 1'b1;
                idx   = IW'((i >= N) ? (i - N) : i);
            end
        end
    end

endmodule

// File: rtl/noc_port_arbiter.sv
// Output-link arbiter: round-robin grant among requesters into a single
// output register held until downstream accepts it.
module noc_port_arbiter
    import pa_noc::*;
#(
    parameter int NUM_REQ      = NUM_PORTS,
    parameter int PACKET_WIDTH = APB_PACKET_WIDTH,
    localparam int GW = $clog2(NUM_REQ)
) (
    input  logic                                  i_clk,
    input  logic                                  i_rst,
    input  logic [NUM_REQ-1:0]                    i_reqValid,
    input  logic [NUM_REQ-1:0][PACKET_WIDTH-1:0]  i_reqPacket,
    output logic [NUM_REQ-1:0]                    o_reqReady,
    output logic                                  o_valid,
    output logic [PACKET_WIDTH-1:0]               o_packet,
    output logic [GW-1:0]                         o_grantIdx,
    input  logic                                  i_ready
);

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    logic [0:0]    state;
    logic [GW-1:0] ptr;
    logic          found;
    logic [GW-1:0] win;
    logic          ld;

    rr_pick #(.N(NUM_REQ)) u_pick (
        .req   (i_reqValid),
        .ptr   (ptr),
        .found (found),
        .idx   (win)
    );

    // The register can take a new packet when empty or when its current one drains.
    assign ld      = (state == ST_EMPTY) || i_ready;
    assign o_valid = (state == ST_FULL);

    always_comb begin
        o_reqReady = '0;
        if (!i_rst && ld && found) begin
            o_reqReady[win] = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= ST_EMPTY;
            ptr        <= GW'(NUM_REQ - 1);
            o_packet   <= '0;
            o_grantIdx <= '0;
        end else if (ld) begin
            if (found) begin
                state      <= ST_FULL;
                ptr        <= win;
                o_packet   <= i_reqPacket[win];
                o_grantIdx <= win;
            end else begin
                state    <= ST_EMPTY;
                o_packet <= '0;
            end
        end
    end

endmodule

// File: tb/tb_noc_port_arbiter.sv
// Directed and randomized bench for noc_port_arbiter against a cycle-level
// reference model of the round-robin output register.
module tb_noc_port_arbiter;

    localparam int NR = 5;
    localparam int PW = 32;
    localparam int GW = 3;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [NR-1:0]            req_valid;
    logic [NR-1:0][PW-1:0]    req_packet;
    logic [NR-1:0]            req_ready;
    logic                     out_valid;
    logic [PW-1:0]            out_packet;
    logic [GW-1:0]            grant_idx;
    logic                     ready;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    bit          m_full;
    logic [PW-1:0] m_pkt;
    int          m_idx;
    int          m_ptr;

    always #5 clk = ~clk;

    noc_port_arbiter #(.NUM_REQ(NR), .PACKET_WIDTH(PW)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_reqValid  (req_valid),
        .i_reqPacket (req_packet),
        .o_reqReady  (req_ready),
        .o_valid     (out_valid),
        .o_packet    (out_packet),
        .o_grantIdx  (grant_idx),
        .i_ready     (ready)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_full = 1'b0;
        m_pkt  = '0;
        m_idx  = 0;
        m_ptr  = NR - 1;
    endtask

    // One clock: check all outputs against the model mid-cycle, then advance the model.
    task automatic do_cycle();
        bit            found;
        bit            ld;
        int            w;
        logic [NR-1:0] exp_rdy;
        found = 1'b0;
        w     = 0;
        for (int k = 1; k <= NR; k++) begin
            int c;
            c = (m_ptr + k) % NR;
            if (!found && req_valid[c]) begin
                found = 1'b1;
                w     = c;
            end
        end
        ld      = !m_full || ready;
        exp_rdy = '0;
        if (!rst && ld && found) exp_rdy[w] = 1'b1;

        @(negedge clk);
        chk("req_ready", 64'(req_ready), 64'(exp_rdy));
        chk("valid",     64'(out_valid), 64'(m_full));
        chk("packet",    64'(out_packet), 64'(m_pkt));
        chk("grant_idx", 64'(grant_idx), 64'(m_idx));

        @(posedge clk);
        if (rst) begin
            model_reset();
        end else if (ld) begin
            if (found) begin
                m_full = 1'b1;
                m_pkt  = req_packet[w];
                m_idx  = w;
                m_ptr  = w;
            end else begin
                m_full = 1'b0;
                m_pkt  = '0;
            end
        end
        #1;
    endtask

    task automatic fill_random_packets();
        for (int r = 0; r < NR; r++) req_packet[r] = $urandom;
    endtask

    task automatic hard_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        rst = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        req_valid  = '0;
        req_packet = '0;
        ready      = 1'b0;
        hard_reset();

        // Reset holds req_ready low even with requests present.
        rst = 1'b1; req_valid = '1; fill_random_packets(); ready = 1'b1;
        do_cycle();
        rst = 1'b0;

        // Single request from index 2.
        fill_random_packets();
        req_valid = 5'b00100; req_packet[2] = 32'h1A3; ready = 1'b1;
        do_cycle();
        chk("single_packet", 64'(out_packet), 64'h1A3);
        chk("single_idx",    64'(grant_idx),  64'd2);
        chk("single_valid",  64'(out_valid),  64'd1);

        // All requesting from reset: grants 0,1,2,3,4,0 back-to-back.
        hard_reset();
        req_valid = '1; ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            fill_random_packets();
            do_cycle();
            chk("rr_order", 64'(grant_idx), 64'(i % NR));
            chk("rr_no_bubble", 64'(out_valid), 64'd1);
        end

        // Backpressure with 0x055 held for 4 cycles.
        fill_random_packets();
        req_valid = 5'b00010; req_packet[1] = 32'h055; ready = 1'b1;
        do_cycle();
        ready = 1'b0; req_valid = '1;
        for (int i = 0; i < 4; i++) begin
            fill_random_packets();
            do_cycle();
            chk("bp_packet", 64'(out_packet), 64'h055);
        end
        ready = 1'b1;
        fill_random_packets();
        do_cycle();
        chk("bp_release_idx", 64'(grant_idx), 64'd2);

        // Sparse requests with wrap.
        fill_random_packets();
        req_valid = 5'b01000; do_cycle();
        chk("sparse_3", 64'(grant_idx), 64'd3);
        req_valid = 5'b10010; fill_random_packets(); do_cycle();
        chk("sparse_4", 64'(grant_idx), 64'd4);
        req_valid = 5'b01010; fill_random_packets(); do_cycle();
        chk("sparse_wrap_1", 64'(grant_idx), 64'd1);

        // Drain to empty.
        req_valid = '0; ready = 1'b1; do_cycle();
        chk("drain_valid",  64'(out_valid),  64'd0);
        chk("drain_packet", 64'(out_packet), 64'd0);
        chk("drain_idx",    64'(grant_idx),  64'd1);
        do_cycle();

        // Reset pulsed while full and stalled.
        req_valid = 5'b10000; fill_random_packets(); do_cycle();
        ready = 1'b0; req_valid = '1;
        rst = 1'b1; do_cycle();
        rst = 1'b0;
        chk("rst_valid",  64'(out_valid),  64'd0);
        chk("rst_packet", 64'(out_packet), 64'd0);
        chk("rst_idx",    64'(grant_idx),  64'd0);
        ready = 1'b1; fill_random_packets(); do_cycle();
        chk("post_rst_grant", 64'(grant_idx), 64'd0);

        // Randomized traffic with occasional reset and stalls.
        for (int i = 0; i < 400; i++) begin
            req_valid = NR'($urandom);
            fill_random_packets();
            ready = ($urandom_range(0, 3) != 0);
            rst   = ($urandom_range(0, 63) == 0);
            do_cycle();
        end
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
